// File: rtl/if_network_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_network_pkg
// Purpose  : Shared defaults and sizing helpers for the IF spiking network.
// Revision : 1.0 - initial release
// ============================================================================
package if_network_pkg;

  localparam int c_def_thresh      = 15;
  localparam int c_def_reset       = 0;
  localparam int c_def_weight_size = 4;
  localparam int c_def_num_inputs  = 4;
  localparam int c_def_num_outputs = 4;
  localparam int c_def_weight_init = 1;
  localparam int c_def_leak        = 1;

  // Potential width: a sub-threshold value plus a full-weight input sum must fit.
  function automatic int pot_width(input int thresh, input int num_inputs,
                                   input int weight_size);
    return $clog2(thresh + num_inputs * ((1 << weight_size) - 1) + 1);
  endfunction

  function automatic int wt_index(input int i, input int j, input int num_outputs);
    return i * num_outputs + j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_neuron.sv
`default_nettype none
// ============================================================================
// Module   : if_neuron
// Purpose  : One integrate-and-fire neuron with registered spike output.
//            Optional leak when IF_NETWORK_LEAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module if_neuron #(
  parameter int THRESH = 15,
  parameter int RESET  = 0,
  parameter int LEAK   = 1,
  parameter int PW     = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] sum,
  output logic          spike
);

`ifdef IF_NETWORK_LEAK_EN
  localparam bit c_leak_en = 1'b1;
`else
  localparam bit c_leak_en = 1'b0;
`endif

  localparam logic [PW-1:0] c_thresh = PW'(THRESH);
  localparam logic [PW-1:0] c_reset  = PW'(RESET);
  localparam logic [PW-1:0] c_leak   = PW'(LEAK);
  // Lowest potential that can take a full LEAK step without dropping below RESET.
  localparam logic [PW:0]   c_floor  = (PW+1)'(RESET + LEAK);

  logic [PW-1:0] r_v;
  logic          r_spike;
  logic [PW-1:0] w_next;
  logic          w_fire;
  logic [PW-1:0] w_leak_v;

  assign w_next   = r_v + sum;
  assign w_fire   = (w_next >= c_thresh);
  assign w_leak_v = ({1'b0, r_v} >= c_floor) ? (r_v - c_leak) : c_reset;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v     <= c_reset;
      r_spike <= 1'b0;
    end else if (w_fire) begin
      r_v     <= c_reset;
      r_spike <= 1'b1;
    end else begin
      r_spike <= 1'b0;
      if (c_leak_en && (sum == '0)) begin
        r_v <= w_leak_v;
      end else begin
        r_v <= w_next;
      end
    end
  end

  assign spike = r_spike;

endmodule
`default_nettype wire

// File: rtl/snn_if_network.sv
`default_nettype none
// ============================================================================
// Module   : snn_if_network
// Purpose  : Fully connected single-layer IF spiking network with a writable
//            weight matrix. Define IF_NETWORK_LEAK_EN to enable neuron leak.
// Revision : 1.0 - initial release
// ============================================================================
module snn_if_network
  import if_network_pkg::*;
#(
  parameter int THRESH      = c_def_thresh,
  parameter int RESET       = c_def_reset,
  parameter int WEIGHT_SIZE = c_def_weight_size,
  parameter int NUM_INPUTS  = c_def_num_inputs,
  parameter int NUM_OUTPUTS = c_def_num_outputs,
  parameter int WEIGHT_INIT = c_def_weight_init,
  parameter int LEAK        = c_def_leak
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_INPUTS-1:0]                      spike_in,
  input  logic                                       wt_we,
  input  logic [$clog2(NUM_INPUTS*NUM_OUTPUTS)-1:0]  wt_addr,
  input  logic [WEIGHT_SIZE-1:0]                     wt_data,
  output logic [NUM_OUTPUTS-1:0]                     spike_out
);

  localparam int c_nw = NUM_INPUTS * NUM_OUTPUTS;
  localparam int c_aw = $clog2(c_nw);
  localparam int c_pw = pot_width(THRESH, NUM_INPUTS, WEIGHT_SIZE);
  localparam logic [c_aw:0] c_nw_l = (c_aw+1)'(c_nw);

  logic [WEIGHT_SIZE-1:0] r_wt [c_nw];
  logic                   w_addr_ok;

  assign w_addr_ok = ({1'b0, wt_addr} < c_nw_l);

  // Integration in the write cycle sees the old weight: the write lands at the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < c_nw; k++) begin
        r_wt[k] <= WEIGHT_SIZE'(WEIGHT_INIT);
      end
    end else if (wt_we && w_addr_ok) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_neuron
    logic [c_pw-1:0] w_sum;

    always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (spike_in[i]) begin
          w_sum = w_sum + c_pw'(r_wt[c_aw'(wt_index(i, j, NUM_OUTPUTS))]);
        end
      end
    end

    if_neuron #(
      .THRESH (THRESH),
      .RESET  (RESET),
      .LEAK   (LEAK),
      .PW     (c_pw)
    ) u_neuron (
      .clk   (clk),
      .rst   (rst),
      .sum   (w_sum),
      .spike (spike_out[j])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_if_network.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_if_network
// Purpose  : Directed self-checking bench for snn_if_network.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_if_network;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] spike_in = 4'h0;
  logic       wt_we = 1'b0;
  logic [3:0] wt_addr = 4'h0;
  logic [3:0] wt_data = 4'h0;
  logic [3:0] spike_out;

  int n_vec = 0;
  int n_err = 0;

  snn_if_network dut (
    .clk       (clk),
    .rst       (rst),
    .spike_in  (spike_in),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .spike_out (spike_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick_check(input string tag, input int k, input logic [3:0] exp);
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d]", tag, k), spike_out, exp);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    spike_in = 4'h0;
    wt_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset held with all inputs active: nothing may integrate or fire.
    rst      = 1'b0;
    spike_in = 4'hF;
    for (int k = 1; k <= 5; k++) tick_check("reset_hold", k, 4'h0);
    rst      = 1'b1;

    // Single input, default weight 1: fire every 15 cycles.
    spike_in = 4'b0001;
    for (int k = 1; k <= 30; k++)
      tick_check("single_in", k, (k % 15 == 0) ? 4'hF : 4'h0);

    // All inputs, weight 1: +4 per cycle, fire every 4th cycle.
    do_reset();
    spike_in = 4'hF;
    for (int k = 1; k <= 12; k++)
      tick_check("multi_in", k, (k % 4 == 0) ? 4'hF : 4'h0);

    // Per-neuron weights: w[1][3]=7 -> neuron 3 fires every 3rd cycle.
    do_reset();
    wt_we = 1'b1; wt_addr = 4'd7; wt_data = 4'd7; spike_in = 4'h0;
    tick_check("w13_write", 0, 4'h0);
    wt_we = 1'b0;
    spike_in = 4'b0010;
    for (int k = 1; k <= 15; k++)
      tick_check("w13_run", k,
                 ((k % 3 == 0) ? 4'b1000 : 4'b0000) | ((k % 15 == 0) ? 4'b0111 : 4'b0000));

    // Write w[0][2]=15 while spiking: old weight used in the write cycle.
    do_reset();
    spike_in = 4'b0001;
    wt_we = 1'b1; wt_addr = 4'd2; wt_data = 4'd15;
    tick_check("wprog", 1, 4'h0);
    wt_we = 1'b0;
    for (int k = 2; k <= 30; k++)
      tick_check("wprog", k, 4'b0100 | ((k % 15 == 0) ? 4'b1011 : 4'b0000));

    // Async reset clears spike_out immediately and discards potential.
    do_reset();
    spike_in = 4'b0001;
    for (int k = 1; k <= 15; k++)
      tick_check("async_a", k, (k == 15) ? 4'hF : 4'h0);
    rst = 1'b0;
    #1;
    check("async_clr", spike_out, 4'h0);
    tick_check("async_hold", 0, 4'h0);
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) tick_check("async_b", k, 4'h0);
    rst = 1'b0;
    #1;
    check("async_mid", spike_out, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 15; k++)
      tick_check("async_c", k, (k == 15) ? 4'hF : 4'h0);

    // Potential 5, idle 8 cycles, then resume: leak drains to 0, else holds 5.
    do_reset();
    spike_in = 4'b0001;
    for (int k = 1; k <= 5; k++) tick_check("leak_up", k, 4'h0);
    spike_in = 4'h0;
    for (int k = 1; k <= 8; k++) tick_check("leak_idle", k, 4'h0);
    spike_in = 4'b0001;
`ifdef IF_NETWORK_LEAK_EN
    for (int k = 1; k <= 15; k++)
      tick_check("leak_resume", k, (k == 15) ? 4'hF : 4'h0);
`else
    for (int k = 1; k <= 15; k++)
      tick_check("leak_resume", k, (k == 10) ? 4'hF : 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
